// File: rtl/cpu_pkg.sv
// cpu_pkg: shared defaults and ALU encodings for the simple-CPU datapath.
// Holds the default word width and register count, the 74181 function-select
// constants used by control, and the arithmetic/logic mode encoding.
package cpu_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_NUM_REGS   = 8;

  // 74181 function selects (S3..S0). Arithmetic meanings apply with M=0,
  // logic meanings with M=1; some codes are shared between the two columns.
  localparam logic [3:0] ALU_PASS = 4'b0000;  // A + cin
  localparam logic [3:0] ALU_ADD  = 4'b1001;  // A + B + cin
  localparam logic [3:0] ALU_SUB  = 4'b0110;  // A - B - 1 + cin
  localparam logic [3:0] ALU_DBL  = 4'b1100;  // A + A + cin
  localparam logic [3:0] ALU_DEC  = 4'b0011;  // -1 + cin
  localparam logic [3:0] LOG_NOTA = 4'b0000;  // ~A
  localparam logic [3:0] LOG_XOR  = 4'b0110;  // A ^ B
  localparam logic [3:0] LOG_AND  = 4'b1011;  // A & B
  localparam logic [3:0] LOG_ONES = 4'b1100;  // all ones
  localparam logic [3:0] LOG_OR   = 4'b1110;  // A | B
  localparam logic [3:0] LOG_A    = 4'b1111;  // A

  // 74181 M input
  typedef enum logic {
    ARITH = 1'b0,
    LOGIC = 1'b1
  } alu_mode_e;

  // Per-slice lookahead terms, active-high, as consumed by 74182-style combining.
  typedef struct packed {
    logic p;
    logic g;
  } slice_pg_t;

  // Fold slice propagate/generate terms, LSB slice first, into one group term.
  function automatic slice_pg_t pg_combine(input slice_pg_t hi, input slice_pg_t lo);
    slice_pg_t r;
    r.p = hi.p & lo.p;
    r.g = hi.g | (hi.p & lo.g);
    return r;
  endfunction

endpackage

// File: rtl/cpu_top_alu181_slice.sv
// alu181_slice: 4-bit 74181 equivalent with active-high data.
//   a, b   : operands
//   s      : function select S3..S0
//   m      : 0 = arithmetic, 1 = logic
//   cn_n   : carry in, active-low (74181 Cn)
//   f      : function output
//   cn4_n  : carry out, active-low (74181 Cn+4)
//   p_n    : slice propagate, active-low
//   g_n    : slice generate, active-low
//   aeqb   : high when F is all ones
module alu181_slice
  import cpu_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       cn_n,
  output logic [3:0] f,
  output logic       cn4_n,
  output logic       p_n,
  output logic       g_n,
  output logic       aeqb
);

  logic [3:0] prop;  // per-bit propagate: A | B&S0 | ~B&S1
  logic [3:0] gen;   // per-bit generate:  A&B&S3 | A&~B&S2 (always implies prop)
  logic [3:0] half;
  logic [4:0] carry;

  // Each bit computes prop + gen + carry; gen implies prop, so the half-sum
  // is prop ^ gen. Logic mode uses the inverted half-sum with carries ignored.
  always_comb begin
    prop  = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
    gen   = (a & b & {4{s[3]}}) | (a & ~b & {4{s[2]}});
    half  = prop ^ gen;
    carry = '0;
    carry[0] = ~cn_n;
    for (int unsigned i = 0; i < 4; i++) begin
      carry[i+1] = gen[i] | (prop[i] & carry[i]);
    end
    f     = m ? ~half : (half ^ carry[3:0]);
    cn4_n = ~carry[4];
    p_n   = ~(&prop);
    g_n   = ~(gen[3]
            | (prop[3] & gen[2])
            | (prop[3] & prop[2] & gen[1])
            | (prop[3] & prop[2] & prop[1] & gen[0]));
    aeqb  = &f;
  end

endmodule

// File: rtl/cpu_top.sv
// cpu_top: simple-CPU datapath. An NUM_REGS x DATA_WIDTH register file with
// two combinational read ports and one synchronous write port feeds a
// ripple-carry ALU built from 74181-style 4-bit slices.
//   clk, reset           : clock; synchronous active-low reset clears all registers
//   reg_write_*          : write strobe / address / data
//   reg_read_addr1/2     : read addresses; port 1 is always ALU operand A
//   alu_comm, alu_mode   : 74181 S3..S0 and M
//   alu_cin              : active-high carry in
//   b_source_sel         : 0 = B from read port 2, 1 = B from alu_b_imm
//   reg_read_data1/2     : read port data
//   alu_result, alu_cout : ALU F and active-high carry out
//   alu_nbo, alu_ngo     : active-low group propagate / generate
module cpu_top
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned NUM_REGS   = DEF_NUM_REGS,
  parameter int unsigned ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reg_write_enable,
  input  logic [ADDR_WIDTH-1:0] reg_write_addr,
  input  logic [DATA_WIDTH-1:0] reg_write_data,
  input  logic [ADDR_WIDTH-1:0] reg_read_addr1,
  input  logic [ADDR_WIDTH-1:0] reg_read_addr2,
  input  logic [3:0]            alu_comm,
  input  logic                  alu_mode,
  input  logic                  alu_cin,
  input  logic                  b_source_sel,
  input  logic [DATA_WIDTH-1:0] alu_b_imm,
  output logic [DATA_WIDTH-1:0] reg_read_data1,
  output logic [DATA_WIDTH-1:0] reg_read_data2,
  output logic [DATA_WIDTH-1:0] alu_result,
  output logic                  alu_cout,
  output logic                  alu_nbo,
  output logic                  alu_ngo
);

  localparam int unsigned NUM_SLICES = DATA_WIDTH / 4;

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  // Address decode by equality against each index, so addresses at or above
  // NUM_REGS match nothing: writes drop and reads return zero.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (reg_write_enable && (reg_write_addr == ADDR_WIDTH'(i))) begin
        regs_d[i] = reg_write_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  always_comb begin
    reg_read_data1 = '0;
    reg_read_data2 = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (reg_read_addr1 == ADDR_WIDTH'(i)) reg_read_data1 = regs_q[i];
      if (reg_read_addr2 == ADDR_WIDTH'(i)) reg_read_data2 = regs_q[i];
    end
  end

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_b;
  logic [NUM_SLICES-1:0] slice_p_n;
  logic [NUM_SLICES-1:0] slice_g_n;
  logic [NUM_SLICES-1:0] slice_aeqb_unused;
  logic                  top_cn4_n;

  always_comb begin
    alu_a = reg_read_data1;
    alu_b = b_source_sel ? alu_b_imm : reg_read_data2;
  end

  // The ripple chain is carried through per-block signals rather than one
  // shared vector so that no net feeds back into itself.
  for (genvar gi = 0; gi < NUM_SLICES; gi++) begin : g_slice
    logic cn_in_n;
    logic cn_out_n;

    if (gi == 0) begin : g_first
      assign cn_in_n = ~alu_cin;
    end else begin : g_chain
      assign cn_in_n = g_slice[gi-1].cn_out_n;
    end

    alu181_slice u_slice (
      .a     (alu_a[gi*4 +: 4]),
      .b     (alu_b[gi*4 +: 4]),
      .s     (alu_comm),
      .m     (alu_mode),
      .cn_n  (cn_in_n),
      .f     (alu_result[gi*4 +: 4]),
      .cn4_n (cn_out_n),
      .p_n   (slice_p_n[gi]),
      .g_n   (slice_g_n[gi]),
      .aeqb  (slice_aeqb_unused[gi])
    );
  end

  assign top_cn4_n = g_slice[NUM_SLICES-1].cn_out_n;

  // 74182-style group terms across every slice; suppressed in logic mode.
  always_comb begin
    slice_pg_t grp;
    slice_pg_t cur;
    grp.p = 1'b1;
    grp.g = 1'b0;
    for (int unsigned i = 0; i < NUM_SLICES; i++) begin
      cur.p = ~slice_p_n[i];
      cur.g = ~slice_g_n[i];
      grp   = pg_combine(cur, grp);
    end
    if (alu_mode == LOGIC) begin
      alu_cout = 1'b0;
      alu_nbo  = 1'b1;
      alu_ngo  = 1'b1;
    end else begin
      alu_cout = ~top_cn4_n;
      alu_nbo  = ~grp.p;
      alu_ngo  = ~grp.g;
    end
  end

endmodule

// File: tb/tb_cpu_top.sv
// tb_cpu_top: directed self-checking bench for cpu_top with hand-computed
// expected values.
module tb_cpu_top;

  logic        clk;
  logic        reset;
  logic        reg_write_enable;
  logic [2:0]  reg_write_addr;
  logic [15:0] reg_write_data;
  logic [2:0]  reg_read_addr1;
  logic [2:0]  reg_read_addr2;
  logic [3:0]  alu_comm;
  logic        alu_mode;
  logic        alu_cin;
  logic        b_source_sel;
  logic [15:0] alu_b_imm;
  logic [15:0] reg_read_data1;
  logic [15:0] reg_read_data2;
  logic [15:0] alu_result;
  logic        alu_cout;
  logic        alu_nbo;
  logic        alu_ngo;

  int unsigned n_checks;
  int unsigned n_errors;

  cpu_top #(
    .DATA_WIDTH (16),
    .NUM_REGS   (8)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .reg_write_enable (reg_write_enable),
    .reg_write_addr   (reg_write_addr),
    .reg_write_data   (reg_write_data),
    .reg_read_addr1   (reg_read_addr1),
    .reg_read_addr2   (reg_read_addr2),
    .alu_comm         (alu_comm),
    .alu_mode         (alu_mode),
    .alu_cin          (alu_cin),
    .b_source_sel     (b_source_sel),
    .alu_b_imm        (alu_b_imm),
    .reg_read_data1   (reg_read_data1),
    .reg_read_data2   (reg_read_data2),
    .alu_result       (alu_result),
    .alu_cout         (alu_cout),
    .alu_nbo          (alu_nbo),
    .alu_ngo          (alu_ngo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [2:0] addr, input logic [15:0] data);
    reg_write_enable = 1'b1;
    reg_write_addr   = addr;
    reg_write_data   = data;
    tick();
    reg_write_enable = 1'b0;
  endtask

  task automatic set_alu(input logic [3:0] s, input logic m, input logic cin,
                         input logic bsel, input logic [15:0] imm);
    alu_comm     = s;
    alu_mode     = m;
    alu_cin      = cin;
    b_source_sel = bsel;
    alu_b_imm    = imm;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0;
    reg_write_enable = 1'b0;
    reg_write_addr = '0;
    reg_write_data = '0;
    reg_read_addr1 = '0;
    reg_read_addr2 = '0;
    alu_comm = '0;
    alu_mode = 1'b0;
    alu_cin = 1'b0;
    b_source_sel = 1'b0;
    alu_b_imm = '0;
    tick();
    tick();
    reset = 1'b1;

    // Reset state: A=0, B=imm=0, S=0000 arith cin=0 gives F=A=0
    reg_read_addr1 = 3'd2;
    reg_read_addr2 = 3'd7;
    #1;
    check("reset_rd1", reg_read_data1, 16'h0000);
    check("reset_rd2", reg_read_data2, 16'h0000);
    check("reset_alu", alu_result, 16'h0000);

    // Basic writes and reads
    write_reg(3'd2, 16'h1234);
    write_reg(3'd3, 16'h5678);
    reg_read_addr1 = 3'd2;
    reg_read_addr2 = 3'd3;
    #1;
    check("rd1_r2", reg_read_data1, 16'h1234);
    check("rd2_r3", reg_read_data2, 16'h5678);

    // No write-through: old value until the writing edge
    reg_read_addr1   = 3'd5;
    reg_write_enable = 1'b1;
    reg_write_addr   = 3'd5;
    reg_write_data   = 16'hAAAA;
    #1;
    check("pre_edge_old", reg_read_data1, 16'h0000);
    tick();
    reg_write_enable = 1'b0;
    check("post_edge_new", reg_read_data1, 16'hAAAA);

    // One-edge reset pulse clears everything
    reset = 1'b0;
    tick();
    reset = 1'b1;
    reg_read_addr1 = 3'd2;
    reg_read_addr2 = 3'd3;
    #1;
    check("rst_pulse_rd1", reg_read_data1, 16'h0000);
    check("rst_pulse_rd2", reg_read_data2, 16'h0000);

    // Arithmetic with register B
    write_reg(3'd2, 16'h1234);
    write_reg(3'd3, 16'h5678);
    set_alu(4'b1001, 1'b0, 1'b0, 1'b0, 16'h0000);
    check("add_res", alu_result, 16'h68AC);
    check("add_cout", alu_cout, 1'b0);
    set_alu(4'b0110, 1'b0, 1'b1, 1'b0, 16'h0000);
    check("sub_res", alu_result, 16'hBBBC);
    set_alu(4'b0000, 1'b0, 1'b1, 1'b0, 16'h0000);
    check("inc_res", alu_result, 16'h1235);

    // Immediate addition
    set_alu(4'b1001, 1'b0, 1'b0, 1'b1, 16'h0005);
    check("addi_res", alu_result, 16'h1239);

    // Logic with immediate
    set_alu(4'b1011, 1'b1, 1'b0, 1'b1, 16'h00FF);
    check("andi_res", alu_result, 16'h0034);
    check("logic_cout", alu_cout, 1'b0);
    check("logic_nbo", alu_nbo, 1'b1);
    check("logic_ngo", alu_ngo, 1'b1);
    set_alu(4'b1110, 1'b1, 1'b0, 1'b1, 16'hFF00);
    check("ori_res", alu_result, 16'hFF34);
    set_alu(4'b0110, 1'b1, 1'b0, 1'b1, 16'hFFFF);
    check("xori_res", alu_result, 16'hEDCB);
    set_alu(4'b0000, 1'b1, 1'b0, 1'b1, 16'h0000);
    check("nota_res", alu_result, 16'hEDCB);
    set_alu(4'b1111, 1'b1, 1'b1, 1'b1, 16'h5555);
    check("passa_res", alu_result, 16'h1234);
    set_alu(4'b1100, 1'b1, 1'b0, 1'b1, 16'h0000);
    check("ones_res", alu_result, 16'hFFFF);

    // Logic with register B
    write_reg(3'd4, 16'h9ABC);
    reg_read_addr2 = 3'd4;
    set_alu(4'b1011, 1'b1, 1'b0, 1'b0, 16'h0000);
    check("and_reg_res", alu_result, 16'h1234);

    // Carry out and group generate/propagate
    write_reg(3'd5, 16'hFFFF);
    reg_read_addr1 = 3'd5;
    set_alu(4'b1001, 1'b0, 1'b0, 1'b1, 16'h0001);
    check("wrap_res", alu_result, 16'h0000);
    check("wrap_cout", alu_cout, 1'b1);
    check("wrap_ngo", alu_ngo, 1'b0);
    check("wrap_nbo", alu_nbo, 1'b0);
    set_alu(4'b1100, 1'b0, 1'b1, 1'b1, 16'h0001);
    check("dbl_ffff_res", alu_result, 16'hFFFF);
    check("dbl_ffff_cout", alu_cout, 1'b1);
    reg_read_addr1 = 3'd2;
    set_alu(4'b1001, 1'b0, 1'b0, 1'b1, 16'h0005);
    check("nocarry_ngo", alu_ngo, 1'b1);
    check("nocarry_nbo", alu_nbo, 1'b1);

    // Decrement from zero
    reg_read_addr1 = 3'd6;
    set_alu(4'b0011, 1'b0, 1'b0, 1'b0, 16'h0000);
    check("dec_res", alu_result, 16'hFFFF);
    check("dec_cout", alu_cout, 1'b0);

    // Chained operation: r6 = r6 + r7, then double it
    write_reg(3'd6, 16'h0005);
    write_reg(3'd7, 16'h0003);
    reg_read_addr1 = 3'd6;
    reg_read_addr2 = 3'd7;
    set_alu(4'b1001, 1'b0, 1'b0, 1'b0, 16'h0000);
    check("chain_add", alu_result, 16'h0008);
    write_reg(3'd6, alu_result);
    check("chain_wb", reg_read_data1, 16'h0008);
    set_alu(4'b1100, 1'b0, 1'b0, 1'b0, 16'h0000);
    check("chain_dbl", alu_result, 16'h0010);

    // Reset wins over a simultaneous write
    reg_read_addr1   = 3'd1;
    reg_write_enable = 1'b1;
    reg_write_addr   = 3'd1;
    reg_write_data   = 16'hBEEF;
    reset            = 1'b0;
    tick();
    reset            = 1'b1;
    reg_write_enable = 1'b0;
    #1;
    check("rst_wr_r1", reg_read_data1, 16'h0000);
    write_reg(3'd1, 16'hBEEF);
    check("wr_r1_after", reg_read_data1, 16'hBEEF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cpu_top.md
# cpu_top

Minimal datapath core: an 8×16 register file with two asynchronous read ports and one synchronous write port, feeding a 16-bit ALU built from cascaded 74181-style 4-bit slices. Operand A always comes from read port 1. Operand B comes from read port 2 or from an immediate input. This is the top of the simple-CPU datapath; control (opcodes, addresses, write data) is driven externally.

## Interface
- DATA_WIDTH, 16, word width; must be a multiple of 4.
- NUM_REGS, 8, number of registers.
- ADDR_WIDTH, $clog2(NUM_REGS), derived register address width.

- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  reset; synchronous and active-low.
- reg_write_enable  in  1  write strobe.
- reg_write_addr  in  ADDR_WIDTH  write address.
- reg_write_data  in  DATA_WIDTH  write data.
- reg_read_addr1  in  ADDR_WIDTH  port-1 address; also the ALU A operand.
- reg_read_addr2  in  ADDR_WIDTH  port-2 address; ALU B operand when b_source_sel=0.
- alu_comm  in  4  74181 function select S3..S0.
- alu_mode  in  1  0 = arithmetic, 1 = logic (74181 M).
- alu_cin  in  1  active-high carry-in (internally Cn = ~alu_cin).
- b_source_sel  in  1  0 = B from register port 2, 1 = B from alu_b_imm.
- alu_b_imm  in  DATA_WIDTH  immediate B operand.
- reg_read_data1  out  DATA_WIDTH  register[reg_read_addr1].
- reg_read_data2  out  DATA_WIDTH  register[reg_read_addr2].
- alu_result  out  DATA_WIDTH  ALU F.
- alu_cout  out  1  active-high carry-out of the top slice.
- alu_nbo  out  1  active-low group propagate across the full word.
- alu_ngo  out  1  active-low group generate across the full word.

## Operation
- Register file:
  - All registers, including register 0, are ordinary read/write registers.
  - Reads are combinational.
  - Writes are accepted only when reg_write_enable=1 and reset is deasserted.
- B mux: B = b_source_sel ? alu_b_imm : reg_read_data2.
- ALU follows the 74181 active-high data table, with Cn = ~alu_cin.
  - M=1 (logic), e.g.: S=1011 → A&B; S=1110 → A|B; S=0110 → A^B; S=0000 → ~A; S=1100 → all ones; S=1111 → A.
  - M=0 (arithmetic), e.g.:
    - S=1001: A+B+cin.
    - S=0110: A−B−1+cin, so A−B when cin=1.
    - S=1100: A+A+cin.
    - S=0011: −1+cin, so FFFF when cin=0.
    - S=0000: A+cin.
  - Results wrap modulo 2^DATA_WIDTH.
- Slices are rippled: each slice's Cn+4 feeds the next slice's Cn.
  - alu_cout = ~Cn+4 of the top slice.
  - alu_nbo / alu_ngo use 74182 group equations over all slices: nBo is low only when every slice P̄ is low; nGo is the combined generate.
- In logic mode, alu_cout is forced to 0 and alu_nbo/alu_ngo are forced to 1.

## Timing
- Reset: when reset=0 at a rising clk edge, all registers clear to 0.
  - Reset has priority over a simultaneous write.
  - Reset asserted mid-sequence discards pending values on that edge.
- After reset, reg_read_data1/2 = 0. alu_result is the combinational function of A=0 and B.
- Write latency: data appears on the read ports immediately after the writing edge. Before that edge the old value is read; there is no write-through bypass.
- ALU outputs are purely combinational from the read addresses, B select, immediate, S, M and cin. Zero-cycle latency; no output registers.
- Out-of-range addresses (≥ NUM_REGS, when not a power of two): reads return 0 and writes are ignored.

## Structure
- Shared package cpu_pkg holds:
  - the DATA_WIDTH/NUM_REGS defaults;
  - named 4-bit function constants, e.g. ALU_ADD=4'b1001, ALU_SUB=4'b0110, ALU_DBL=4'b1100, ALU_DEC=4'b0011, LOG_AND=4'b1011, LOG_OR=4'b1110;
  - the mode constants ARITH=0 and LOGIC=1.
- One sub-module, alu181_slice: a 4-bit 74181 equivalent (A, B, S, M, Cn → F, Cn+4, P̄, Ḡ, A=B).
  - It is instantiated DATA_WIDTH/4 times via generate.
  - Group P/G combining and the register file live in cpu_top.

## Test plan
- Reset, then write r2=1234 and r3=5678. Read addr1=2, addr2=3 → 1234 / 5678. Pulse reset low for one edge → both read 0000.
- Addition and subtraction, A=r2=1234 and B=r3 (M=0):
  - S=1001, cin=0 → 68AC, cout=0.
  - S=0110, cin=1 → BBBC.
- Immediate addition: S=1001, b_sel=1, imm=0005 → 1239.
- Logic immediate, A=1234 (M=1):
  - S=1011, imm=00FF → 0034.
  - S=1110, imm=FF00 → FF34.
- Logic with register B: r4=9ABC, S=1011, b_sel=0 → 1234.
- Carry and decrement:
  - A=FFFF, S=1001, M=0, imm=0001, cin=0 → 0000, cout=1, nGo=0.
  - A=FFFF, S=1100, cin=1 → FFFF, cout=1.
  - r6=0000, S=0011, M=0, cin=0 → FFFF.
- Chained operation with r6=5, r7=3:
  - S=1001 → 0008; write this result back to r6.
  - S=1100, M=0, cin=0 → 0010.
- Write and reset on the same edge: r1 is unchanged from 0000.
